// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK bank command sequencer.
package jk_ctrl_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_APPLY  = 2'b01;
    localparam logic [1:0] ST_SETTLE = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

endpackage

// File: rtl/jk_apply_cnt.sv
// Loadable down-counter for the apply phase; a load of zero counts as one cycle.
module jk_apply_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_eff;

    assign load_eff = (load_val == '0) ? CNT_W'(1) : load_val;

    // last is registered alongside cnt so it flags the final apply cycle directly
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            last <= 1'b0;
        end else if (load) begin
            cnt  <= load_eff;
            last <= (load_eff == CNT_W'(1));
        end else if (en && !last) begin
            cnt  <= cnt - CNT_W'(1);
            last <= (cnt == CNT_W'(2));
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command-driven j/k driver for a JK flip-flop bank: apply, settle, snapshot, report.
module jk_cmd_sequencer
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_snap
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_last;

    jk_apply_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cmd_count),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // j/k registers hold the command encoding themselves, so op/mask need no separate latch
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        j_nxt     = '0;
        k_nxt     = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_APPLY;
                    case (cmd_op)
                        OP_SET:  j_nxt = cmd_mask;
                        OP_CLR:  k_nxt = cmd_mask;
                        OP_TGL: begin
                            j_nxt = cmd_mask;
                            k_nxt = cmd_mask;
                        end
                        default: ;
                    endcase
                end
            end
            ST_APPLY: begin
                if (cnt_last) begin
                    state_nxt = ST_SETTLE;
                end else begin
                    cnt_en = 1'b1;
                    j_nxt  = j_out;
                    k_nxt  = k_out;
                end
            end
            ST_SETTLE: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            j_out     <= '0;
            k_out     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            q_snap    <= '0;
        end else begin
            j_out     <= j_nxt;
            k_out     <= k_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
            if (state == ST_SETTLE) begin
                q_snap <= q_in;
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench: JK bank on the sequencer outputs, checked against a command-level Q model.
module tb_jk_cmd_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic [WIDTH-1:0] q_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q_snap;

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] model_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_count (cmd_count),
        .j_out     (j_out),
        .k_out     (k_out),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .q_snap    (q_snap)
    );

    // JK flip-flop bank, reset together with the sequencer
    always_ff @(posedge clk) begin
        if (rst) bank_q <= '0;
        else     bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end
    assign q_in = bank_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] ctl(input logic b, input logic d, input logic r,
                                        input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k);
        return {b, d, r, j, k};
    endfunction

    // One command from the accept edge through the return to IDLE; called at a negedge.
    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                           input logic [CNT_W-1:0] cnt, input bit hold_valid);
        int n;
        int w;
        logic [WIDTH-1:0] ej;
        logic [WIDTH-1:0] ek;
        w = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 32'(cmd_ready), 32'd1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_count = cnt;
        n  = (cnt == 0) ? 1 : int'(cnt);
        ej = '0;
        ek = '0;
        case (op)
            2'b01: begin ej = mask; model_q = model_q | mask; end
            2'b10: begin ek = mask; model_q = model_q & ~mask; end
            2'b11: begin
                ej = mask;
                ek = mask;
                if (n % 2 == 1) model_q = model_q ^ mask;
            end
            default: ;
        endcase
        @(negedge clk);
        for (int c = 1; c <= n + 3; c++) begin
            if (c <= n)
                check("apply", 32'(ctl(busy, done, cmd_ready, j_out, k_out)), 32'(ctl(1, 0, 0, ej, ek)));
            else if (c == n + 1)
                check("settle", 32'(ctl(busy, done, cmd_ready, j_out, k_out)), 32'(ctl(1, 0, 0, '0, '0)));
            else if (c == n + 2) begin
                check("done", 32'(ctl(busy, done, cmd_ready, j_out, k_out)), 32'(ctl(1, 1, 0, '0, '0)));
                check("q_snap", 32'(q_snap), 32'(model_q));
            end else begin
                check("idle", 32'(ctl(busy, done, cmd_ready, j_out, k_out)), 32'(ctl(0, 0, 1, '0, '0)));
                check("q_snap_hold", 32'(q_snap), 32'(model_q));
            end
            if (c < n + 3) begin
                cmd_valid = hold_valid;
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_mask  = WIDTH'($urandom);
                cmd_count = CNT_W'($urandom);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_mask  = '0;
        cmd_count = '0;
        model_q   = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctl", 32'(ctl(busy, done, cmd_ready, j_out, k_out)), 32'(ctl(0, 0, 0, '0, '0)));
        check("reset_snap", 32'(q_snap), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(2'b01, 4'b0101, 8'd1, 1'b0);
        run_cmd(2'b11, 4'b1111, 8'd3, 1'b1);
        run_cmd(2'b01, 4'b0100, 8'd1, 1'b0);
        run_cmd(2'b10, 4'b0010, 8'd2, 1'b1);
        run_cmd(2'b10, 4'b0100, 8'd0, 1'b0);
        run_cmd(2'b00, 4'b1111, 8'd5, 1'b1);
        for (int i = 0; i < 30; i++)
            run_cmd(2'($urandom_range(0, 3)), WIDTH'($urandom), CNT_W'($urandom_range(0, 12)),
                    1'($urandom_range(0, 1)));
        run_cmd(2'b11, 4'b1001, 8'd255, 1'b1);
        run_cmd(2'b01, 4'b1111, 8'd2, 1'b0);
        cmd_valid = 1'b0;

        // reset in the middle of a TOGGLE apply phase, with a command also presented
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_mask  = 4'b1111;
        cmd_count = 8'd10;
        repeat (3) @(negedge clk);
        check("mid_apply_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctl", 32'(ctl(busy, done, cmd_ready, j_out, k_out)), 32'(ctl(0, 0, 0, '0, '0)));
        check("abort_snap", 32'(q_snap), 32'd0);
        check("abort_state", 32'(dut.state), 32'(jk_ctrl_pkg::ST_IDLE));
        rst       = 1'b0;
        cmd_valid = 1'b0;
        model_q   = '0;
        @(negedge clk);
        check("post_reset_idle", 32'(ctl(busy, done, cmd_ready, j_out, k_out)), 32'(ctl(0, 0, 1, '0, '0)));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'({busy, done}), 32'd0);
        end
        run_cmd(2'b11, 4'b0110, 8'd3, 1'b0);
        cmd_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
